// File: rtl/fp_div.sv
// fp_div: iterative single-precision divider (operand1 / operand2).
// Restoring radix-2 mantissa division, one quotient bit per clock.
// Normal inputs only, truncating, 8-bit wrapping exponent arithmetic.
//
//  state | meaning
//  ------+---------------------------------------------------------
//  IDLE  | waiting for start; result/div_by_zero hold last values
//  DIV   | 25 restoring iterations, cnt counts 24 down to 0
//  NORM  | normalise, apply special cases, register result, pulse done
module fp_div #(
  parameter int EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2
  } state_t;

  localparam logic [7:0] BIAS8 = EXP_BIAS[7:0];

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [24:0] rem;
  logic [24:0] quot;

  logic [23:0] m1;
  logic [23:0] m2;
  logic        rem_ge;
  logic [23:0] rem_sub;
  logic [24:0] rem_next;
  logic        sign_res;
  logic [7:0]  exp_base;
  logic [7:0]  exp_res;
  logic [22:0] mant_res;
  logic [31:0] norm_word;
  logic        norm_dbz;

  assign m1 = {1'b1, op1[22:0]};
  assign m2 = {1'b1, op2[22:0]};

  // One restoring step; a successful subtraction leaves less than m2, so 24 bits suffice.
  always_comb begin
    rem_ge   = (rem >= {1'b0, m2});
    rem_sub  = rem[23:0] - m2;
    rem_next = rem_ge ? {rem_sub, 1'b0} : {rem[23:0], 1'b0};
  end

  // Normalisation and special-case selection for the NORM cycle.
  always_comb begin
    sign_res = op1[31] ^ op2[31];
    exp_base = op1[30:23] - op2[30:23] + BIAS8;
    if (quot[24]) begin
      exp_res  = exp_base;
      mant_res = quot[23:1];
    end else begin
      exp_res  = exp_base - 8'd1;
      mant_res = quot[22:0];
    end
    norm_dbz = 1'b0;
    if (op2 == 32'h0) begin
      norm_word = {sign_res, 8'hFF, 23'h0};
      norm_dbz  = 1'b1;
    end else if (op1 == 32'h0) begin
      norm_word = 32'h0;
    end else begin
      norm_word = {sign_res, exp_res, mant_res};
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      op1         <= 32'h0;
      op2         <= 32'h0;
      rem         <= 25'h0;
      quot        <= 25'h0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= 32'h0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op1   <= operand1;
            op2   <= operand2;
            rem   <= {1'b0, 1'b1, operand1[22:0]};
            quot  <= 25'h0;
            cnt   <= 5'd24;
            busy  <= 1'b1;
            state <= DIV;
          end
        end
        DIV: begin
          rem  <= rem_next;
          quot <= {quot[23:0], rem_ge};
          if (cnt == 5'd0) begin
            state <= NORM;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        NORM: begin
          result      <= norm_word;
          div_by_zero <= norm_dbz;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div.sv
// Directed testbench for fp_div: latency, numerics, special cases, handshake.
module tb_fp_div;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_by_zero;

  int checks;
  int failures;

  fp_div #(.EXP_BIAS(127)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .operand1(operand1),
    .operand2(operand2),
    .busy(busy),
    .done(done),
    .result(result),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands with start for exactly one rising edge (E0); returns #1 after E0.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    operand1 = a;
    operand2 = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    operand1 = 32'hDEADBEEF;
    operand2 = 32'h12345678;
  endtask

  // Counts edges after the last start edge until done is seen (99 on timeout).
  task automatic wait_done(output int n);
    n = 99;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    operand1 = 32'h0;
    operand2 = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, result, div_by_zero} !== 35'h0) begin
      failures++;
      $display("FAIL reset_asserted: busy=%b done=%b result=%h dbz=%b required all 0",
               busy, done, result, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, result, div_by_zero} !== 35'h0) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: busy=%b done=%b result=%h dbz=%b required all 0",
                 i, busy, done, result, div_by_zero);
      end
    end
  endtask

  task automatic test_latency_q24_set;
    int n;
    int busy_bad;
    busy_bad = 0;
    launch(32'h40C00000, 32'h40000000);
    n = 99;
    for (int i = 1; i <= 40; i++) begin
      if (i <= 26 && busy !== 1'b1) busy_bad++;
      if (i <= 25 && done !== 1'b0) busy_bad++;
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 26) begin
      failures++;
      $display("FAIL latency_6div2: done after %0d edges, required 26", n);
    end
    checks++;
    if (busy_bad != 0) begin
      failures++;
      $display("FAIL busy_window_6div2: %0d bad cycles, required 0", busy_bad);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_at_done: got %b required 0", busy);
    end
    checks++;
    if (result !== 32'h40400000 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL div_6div2: got %h/%b required 40400000/0", result, div_by_zero);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || result !== 32'h40400000) begin
      failures++;
      $display("FAIL done_pulse_hold: done=%b result=%h required 0/40400000", done, result);
    end
  endtask

  task automatic test_truncation;
    int n;
    launch(32'h3F800000, 32'h40400000);
    wait_done(n);
    checks++;
    if (n != 26 || result !== 32'h3EAAAAAA || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL div_1div3: lat=%0d result=%h dbz=%b required 26/3eaaaaaa/0",
               n, result, div_by_zero);
    end
  endtask

  task automatic test_sign;
    int n;
    launch(32'hC1000000, 32'h40000000);
    wait_done(n);
    checks++;
    if (n != 26 || result !== 32'hC0800000 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL div_m8div2: lat=%0d result=%h dbz=%b required 26/c0800000/0",
               n, result, div_by_zero);
    end
  endtask

  task automatic test_special;
    int n;
    launch(32'h00000000, 32'h40A00000);
    wait_done(n);
    checks++;
    if (n != 26 || result !== 32'h00000000 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL zero_dividend: lat=%0d result=%h dbz=%b required 26/00000000/0",
               n, result, div_by_zero);
    end
    launch(32'h3F800000, 32'h00000000);
    wait_done(n);
    checks++;
    if (n != 26 || result !== 32'h7F800000 || div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL div_by_zero: lat=%0d result=%h dbz=%b required 26/7f800000/1",
               n, result, div_by_zero);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (div_by_zero !== 1'b1 || result !== 32'h7F800000) begin
      failures++;
      $display("FAIL dbz_hold: result=%h dbz=%b required 7f800000/1", result, div_by_zero);
    end
    launch(32'h00000000, 32'h00000000);
    wait_done(n);
    checks++;
    if (n != 26 || result !== 32'h7F800000 || div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL zero_div_zero: lat=%0d result=%h dbz=%b required 26/7f800000/1",
               n, result, div_by_zero);
    end
  endtask

  task automatic test_ignored_start;
    int n;
    launch(32'h40C00000, 32'h40000000);
    repeat (4) @(posedge clk);
    @(negedge clk);
    operand1 = 32'h41000000;
    operand2 = 32'h40800000;
    start    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_during_ignored: got %b required 1", busy);
    end
    n = 99;
    for (int i = 8; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 26 || result !== 32'h40400000) begin
      failures++;
      $display("FAIL ignored_start: lat=%0d result=%h required 26/40400000", n, result);
    end
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || result !== 32'h40400000) begin
      failures++;
      $display("FAIL no_queued_op: busy=%b result=%h required 0/40400000", busy, result);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    launch(32'h40C00000, 32'h40000000);
    wait_done(n);
    operand1 = 32'h41000000;
    operand2 = 32'h40800000;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    operand1 = 32'h0;
    operand2 = 32'h0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || result !== 32'h40400000) begin
      failures++;
      $display("FAIL b2b_accept: busy=%b done=%b result=%h required 1/0/40400000",
               busy, done, result);
    end
    wait_done(n);
    checks++;
    if (n != 26 || result !== 32'h40000000 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL b2b_result: lat=%0d result=%h dbz=%b required 26/40000000/0",
               n, result, div_by_zero);
    end
  endtask

  task automatic test_abort;
    int n;
    int spurious;
    launch(32'h40C00000, 32'h40000000);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, div_by_zero} !== 35'h0) begin
      failures++;
      $display("FAIL abort_reset: busy=%b done=%b result=%h dbz=%b required all 0",
               busy, done, result, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      failures++;
      $display("FAIL abort_no_done: %0d active cycles, required 0", spurious);
    end
    launch(32'h40400000, 32'h3F800000);
    wait_done(n);
    checks++;
    if (n != 26 || result !== 32'h40400000 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL after_abort: lat=%0d result=%h dbz=%b required 26/40400000/0",
               n, result, div_by_zero);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_latency_q24_set();
    test_truncation();
    test_sign();
    test_special();
    test_ignored_start();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
